// File: rtl/fmes_recip_nper.sv
// Reciprocal frequency meter: counts clk cycles over nper periods of Ux,
// then divides CLK_HZ*nper by that count with a bit-serial restoring divider.
module fmes_recip_nper #(
   parameter int CLK_HZ = 50_000_000,
   parameter int W_Q    = 32,
   parameter int W_F    = 16,
   parameter int TMO_CE = 200_000
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ce,
   input  logic           Ux,
   input  logic           st,
   input  logic [3:0]     nper,
   output logic [W_Q-1:0] Q,
   output logic [W_F-1:0] F,
   output logic           busy,
   output logic           ok_DIV,
   output logic           tmo,
   output logic           ovf
);

   localparam int W_T = $clog2(TMO_CE + 1);
   localparam int W_I = $clog2(W_Q + 1);
   localparam logic [W_Q-1:0] CLK_V = W_Q'(CLK_HZ);

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_COUNT, S_DIV, S_DONE} state_t;

   state_t         r_state;
   logic           r_s1, r_s2, r_s3;
   logic [3:0]     r_nper;
   logic [3:0]     r_ecnt;
   logic [W_Q-1:0] r_cnt;
   logic [W_T-1:0] r_tcnt;
   logic [W_Q-1:0] r_num;
   logic [W_Q:0]   r_rem;
   logic [W_I-1:0] r_it;
   logic [W_Q-1:0] r_q;
   logic [W_F-1:0] r_f;
   logic           r_busy, r_ok, r_tmo, r_ovf;

   logic           w_ue;
   logic           w_tmo;
   logic           w_sat;
   logic [W_Q-1:0] w_numer;
   logic [W_Q:0]   w_trial;
   logic [W_Q:0]   w_diff;
   logic           w_ge;
   logic           w_qhi;

   assign w_ue    = r_s2 & ~r_s3;
   // Level compare on a saturating tick count, so a timeout that loses to an
   // edge in the same cycle still fires on the following cycle.
   assign w_tmo   = (r_tcnt == W_T'(TMO_CE));
   assign w_sat   = &r_cnt;
   assign w_numer = CLK_V * W_Q'(r_nper);
   assign w_trial = {r_rem[W_Q-1:0], r_num[W_Q-1]};
   assign w_diff  = w_trial - {1'b0, r_q};
   assign w_ge    = (w_trial >= {1'b0, r_q});
   assign w_qhi   = |r_num[W_Q-1:W_F];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= Ux;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_nper  <= 4'd1;
         r_ecnt  <= '0;
         r_cnt   <= '0;
         r_tcnt  <= '0;
         r_num   <= '0;
         r_rem   <= '0;
         r_it    <= '0;
         r_q     <= '0;
         r_f     <= '0;
         r_busy  <= 1'b0;
         r_ok    <= 1'b0;
         r_tmo   <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_ok <= 1'b0;
         if ((r_state == S_ARM || r_state == S_COUNT) && ce && !w_tmo)
            r_tcnt <= r_tcnt + 1'b1;
         case (r_state)
            S_IDLE: begin
               if (st) begin
                  r_nper  <= (nper == 4'd0) ? 4'd1 : nper;
                  r_cnt   <= '0;
                  r_ecnt  <= '0;
                  r_tcnt  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_ARM;
               end
            end
            S_ARM: begin
               if (w_ue) begin
                  r_cnt   <= '0;
                  r_ecnt  <= '0;
                  r_state <= S_COUNT;
               end else if (w_tmo) begin
                  r_q     <= r_cnt;
                  r_f     <= '0;
                  r_tmo   <= 1'b1;
                  r_ovf   <= 1'b0;
                  r_ok    <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_COUNT: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_ue && (r_ecnt + 4'd1 == r_nper)) begin
                  // +1 covers the cycle of the closing edge itself
                  r_q     <= r_cnt + 1'b1;
                  r_num   <= w_numer;
                  r_rem   <= '0;
                  r_it    <= '0;
                  r_state <= S_DIV;
               end else if (w_ue) begin
                  r_ecnt <= r_ecnt + 4'd1;
               end else if (w_tmo || w_sat) begin
                  r_q     <= r_cnt;
                  r_f     <= '0;
                  r_tmo   <= 1'b1;
                  r_ovf   <= 1'b0;
                  r_ok    <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DIV: begin
               if (r_it == W_I'(W_Q)) begin
                  r_f     <= w_qhi ? '1 : r_num[W_F-1:0];
                  r_ovf   <= w_qhi;
                  r_tmo   <= 1'b0;
                  r_ok    <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  // numerator shifts out MSB-first; quotient bits shift in at LSB
                  r_rem <= w_ge ? w_diff : w_trial;
                  r_num <= {r_num[W_Q-2:0], w_ge};
                  r_it  <= r_it + 1'b1;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign Q      = r_q;
   assign F      = r_f;
   assign busy   = r_busy;
   assign ok_DIV = r_ok;
   assign tmo    = r_tmo;
   assign ovf    = r_ovf;

endmodule

// File: tb/tb_fmes_recip_nper.sv
// Directed bench for fmes_recip_nper: 50 MHz clk, Ux from a free-running
// generator, short timeout so every scenario fits in a modest run.
`timescale 1ns/1ps
module tb_fmes_recip_nper;
   localparam int W_Q = 32;
   localparam int W_F = 16;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           ce = 1'b0;
   logic           Ux = 1'b0;
   logic           st = 1'b0;
   logic [3:0]     nper = 4'd0;
   logic [W_Q-1:0] Q;
   logic [W_F-1:0] F;
   logic           busy, ok_DIV, tmo, ovf;

   int total = 0;
   int bad = 0;
   int ux_half = 10000;
   bit ux_en = 1'b1;
   int got_ok, qc, oc;
   logic [31:0] m_q, m_f, m_tmo, m_ovf;

   fmes_recip_nper #(.CLK_HZ(50_000_000), .W_Q(W_Q), .W_F(W_F), .TMO_CE(120)) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .Ux(Ux), .st(st), .nper(nper),
      .Q(Q), .F(F), .busy(busy), .ok_DIV(ok_DIV), .tmo(tmo), .ovf(ovf)
   );

   always #10 clk = ~clk;

   // Ux edges land 7 ns after a multiple of 20 ns, clear of the posedges at 10 mod 20
   initial begin
      #7;
      forever begin
         if (ux_en) begin
            Ux = 1'b1; #(ux_half);
            Ux = 1'b0; #(ux_half);
         end else begin
            Ux = 1'b0; #20;
         end
      end
   end

   initial begin
      forever begin
         repeat (249) @(negedge clk);
         ce = 1'b1;
         @(negedge clk);
         ce = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Start a measurement, optionally re-strike st at loop cycle rs, wait for ok_DIV.
   task automatic measure(input string tag, input logic [3:0] np, input int lim, input int rs);
      logic [31:0] q0;
      q0 = Q;
      @(negedge clk); st = 1'b1; nper = np;
      @(negedge clk); st = 1'b0;
      chk({tag, "_busy_after_st"}, busy, 1);
      got_ok = 0; qc = -1; oc = -1;
      for (int i = 0; i < lim; i++) begin
         st = (i == rs);
         if (i == rs) nper = 4'd4;
         @(negedge clk);
         if (qc < 0 && Q !== q0) qc = i;
         if (ok_DIV === 1'b1) begin
            oc = i; got_ok = 1;
            break;
         end
      end
      st = 1'b0;
      chk({tag, "_ok_seen"}, got_ok, 1);
      m_q = Q; m_f = 32'(F); m_tmo = 32'(tmo); m_ovf = 32'(ovf);
      @(negedge clk);
      chk({tag, "_ok_one_cycle"}, ok_DIV, 0);
      chk({tag, "_busy_drop"}, busy, 0);
   endtask

   task automatic chk_res(input string tag, input int eq, input int ef, input int et, input int eo);
      chk({tag, "_Q"}, m_q, eq);
      chk({tag, "_F"}, m_f, ef);
      chk({tag, "_tmo"}, m_tmo, et);
      chk({tag, "_ovf"}, m_ovf, eo);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_Q0"}, Q, 0);
      chk({tag, "_F0"}, F, 0);
      chk({tag, "_busy0"}, busy, 0);
      chk({tag, "_ok0"}, ok_DIV, 0);
      chk({tag, "_tmo0"}, tmo, 0);
      chk({tag, "_ovf0"}, ovf, 0);
   endtask

   task automatic no_ok(input string tag, input int n);
      int cnt;
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (ok_DIV === 1'b1) cnt++;
      end
      chk({tag, "_no_extra_ok"}, cnt, 0);
   endtask

   task automatic sync_ux();
      @(posedge Ux);
      @(posedge Ux);
   endtask

   initial begin
      int found;
      logic [31:0] q0;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      sync_ux();

      // 20 us period, single period; also the Q-latch to ok_DIV distance
      measure("t1", 4'd1, 5000, -1);
      chk_res("t1", 1000, 50000, 0, 0);
      chk("t1_latency", oc - qc, W_Q + 1);

      measure("t2", 4'd4, 8000, -1);
      chk_res("t2", 4000, 50000, 0, 0);

      measure("t3", 4'd0, 5000, -1);
      chk_res("t3", 1000, 50000, 0, 0);

      // start right after a Ux rise so loop cycle 1500 falls inside COUNT
      @(posedge Ux);
      repeat (10) @(negedge clk);
      measure("t7", 4'd1, 5000, 1500);
      chk_res("t7", 1000, 50000, 0, 0);
      no_ok("t7", 3000);

      // reset in the middle of the division
      q0 = Q;
      @(negedge clk); st = 1'b1; nper = 4'd2;
      @(negedge clk); st = 1'b0;
      found = 0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (Q !== q0) begin found = 1; break; end
      end
      chk("t8_q_latch", found, 1);
      chk("t8_q_val", Q, 2000);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_zero("t8");
      rst_n = 1'b1;
      no_ok("t8", 3000);

      measure("t9", 4'd1, 5000, -1);
      chk_res("t9", 1000, 50000, 0, 0);

      // slow input, floor division: 50e6/6172 = 8101.1
      ux_half = 61720;
      sync_ux();
      measure("t4", 4'd1, 20000, -1);
      chk_res("t4", 6172, 8101, 0, 0);

      // 1 us period, nper=2: quotient 1e6 saturates
      ux_half = 500;
      sync_ux();
      measure("t5", 4'd2, 2000, -1);
      chk_res("t5", 100, 65535, 0, 1);

      // Ux held low: timeout after 120 ce ticks, counter never left 0 in ARM
      ux_en = 1'b0;
      #3000;
      measure("t6", 4'd1, 40000, -1);
      chk_res("t6", 0, 0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fmes_recip_nper.md
# fmes_recip_nper

Parametrised reciprocal frequency meter, the successor to the single-period measurement block. On a start strobe it measures the input `Ux` over `nper` consecutive periods by counting `clk` cycles. It then computes F = CLK_HZ·nper / Q with an on-block sequential divider and reports the result with a one-cycle `ok_DIV` pulse. It also adds a timeout, saturation flags and a busy handshake. It sits between the `Ux` input conditioning and the display/indicator path, and is paced by the system `ce` tick.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000 — `clk` frequency in Hz; numerator base.
- `W_Q`, 32 — period-counter width; also the number of divider iterations.
- `W_F`, 16 — result width.
- `TMO_CE`, 200_000 — timeout in `ce` ticks (2 s at 100 kHz).

Ports:
- `clk` in 1 — system clock; the only clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `ce` in 1 — one-`clk` enable tick; used only for the timeout count.
- `Ux` in 1 — measured signal, asynchronous to `clk`.
- `st` in 1 — start strobe, one `clk` wide.
- `nper` in 4 — number of periods to average; sampled at `st`; 0 is treated as 1.
- `Q` out W_Q — latched `clk`-cycle count over `nper` periods.
- `F` out W_F — frequency in Hz, saturated.
- `busy` out 1 — high from the cycle after accepted `st` until the `ok_DIV` cycle inclusive.
- `ok_DIV` out 1 — one-cycle pulse: `Q`, `F`, `tmo` and `ovf` are valid.
- `tmo` out 1 — the last measurement timed out.
- `ovf` out 1 — the last result saturated (`F` clipped).

## Operation
- **Input conditioning:** `Ux` passes through a 2-FF synchronizer plus one delay FF. Rising-edge pulse `ue` = sync2 & ~sync3.
- **FSM states:** IDLE, ARM, COUNT, DIV, DONE.
- **IDLE:** on `st`, latch `nper` (0→1) and clear the counter, edge count and ce-tick count. Go to ARM. `tmo` and `ovf` hold their previous values until DONE.
- **ARM:** wait for `ue`. On `ue`, clear the counter to 0, set edge count to 0, go to COUNT.
- **COUNT:** the counter increments every `clk`.
  - On `ue`, the edge count increments.
  - When the edge count reaches `nper`, latch `Q` = counter + 1, i.e. the exact number of `clk` cycles between the first and the `nper`-th later edge. Go to DIV.
- **Timeout:** in ARM or COUNT, `ce` ticks are counted. On reaching `TMO_CE`, or on the counter reaching all-ones, go to DONE with `tmo`=1, `F`=0, and `Q` = the counter value.
- **DIV:** restoring division of N = CLK_HZ·nper by `Q`, one quotient bit per `clk`, W_Q iterations.
  - The numerator register is wide enough for CLK_HZ·15.
  - If the quotient ≥ 2^W_F: `F` = all-ones, `ovf`=1. Otherwise `F` = quotient (floor), `ovf`=0.
  - `tmo`=0.
- **DONE:** assert `ok_DIV` for one cycle, then go to IDLE.
- **`st` while busy:** ignored.
- **Simultaneous events:** `ue` and the timeout in the same cycle — the edge wins. Measurement completion takes priority over timeout.

## Timing
- **Reset:** all outputs 0 (`Q`, `F`, `busy`, `ok_DIV`, `tmo`, `ovf`). FSM in IDLE; synchronizer flops cleared.
- **Reset mid-operation:** aborts immediately to the reset state. No `ok_DIV` is produced.
- **`st` to `busy`:** `st` sampled high at edge k gives `busy`=1 from k+1.
- **`Ux` to `ue`:** a `Ux` rise appears as `ue` 2–3 `clk` later. The delay is identical for every edge, so `Q` is exact to ±1 cycle of jitter.
- **Division latency:** `Q` is latched at edge L. Division runs L+1..L+W_Q. `F` and `ok_DIV` are registered at L+W_Q+1. `busy` drops at L+W_Q+2.
- **Timeout path:** `ok_DIV` follows the timeout-detection cycle by one `clk` (no division).
- **Output hold:** `F`, `Q`, `tmo` and `ovf` are stable from `ok_DIV` until the next `ok_DIV` or reset.

## Test plan
- **Single period:** `Ux` period 20 µs, `nper`=1, `st` → `Q`=1000, `F`=50000, `tmo`=0, `ovf`=0, `ok_DIV` pulse exactly W_Q+1 cycles after `Q` latch.
- **Averaging and nper=0:** `Ux` period 20 µs, `nper`=4 → `Q`=4000, `F`=50000. Repeat with `nper`=0 → behaves as `nper`=1 (`Q`=1000).
- **Slow input:** `Ux` period 20 408 163 ns (49 Hz), `nper`=1 → `Q`=1020408, `F`=49.
- **Saturation:** `Ux` period 1 µs, `nper`=2 → `Q`=100, quotient 1 000 000 → `F`=65535, `ovf`=1.
- **Timeout:** `Ux` held low, `st`, `ce` every 500 `clk` → after 200 000 ce ticks, `ok_DIV` pulse with `tmo`=1, `F`=0.
- **Robustness:** second `st` during COUNT is ignored (single `ok_DIV`). `rst_n` pulsed low during DIV → outputs 0, FSM IDLE, no `ok_DIV`. Fresh `st` then measures correctly.
